// File: rtl/occupancy_grid_arbiter_pkg.sv
// occupancy_pkg: shared grid types, arbiter state codes and log-odds limits
package occupancy_pkg;
    localparam int GRID_ADDR_WIDTH = 14;
    localparam int LOGODDS_WIDTH = 8;
    typedef logic [GRID_ADDR_WIDTH-1:0] grid_addr_t;
    typedef logic signed [LOGODDS_WIDTH-1:0] logodds_t;
    typedef logic [1:0] arb_state_t;
    localparam arb_state_t IDLE = 2'd0;
    localparam arb_state_t CLEAR = 2'd1;
    localparam arb_state_t UPD_WAIT = 2'd2;
    localparam arb_state_t UPD_WR = 2'd3;
    localparam logodds_t LOGODDS_MAX = logodds_t'(2 ** (LOGODDS_WIDTH - 1) - 1);
    localparam logodds_t LOGODDS_MIN = logodds_t'(-(2 ** (LOGODDS_WIDTH - 1)));
endpackage

// File: rtl/occupancy_grid_arbiter_if.sv
// occupancy_grid_arbiter_if: control, ray-tracer, VGA and BRAM signals of the grid arbiter
interface occupancy_grid_arbiter_if
    import occupancy_pkg::*;
#(
    parameter int ADDR_WIDTH = GRID_ADDR_WIDTH,
    parameter int DATA_WIDTH = LOGODDS_WIDTH
);
    logic zero_occupancy_grid;
    logic occupancy_busy;
    logic upd_req;
    logic [ADDR_WIDTH-1:0] upd_addr;
    logic [DATA_WIDTH-1:0] upd_delta;
    logic upd_gnt;
    logic upd_done;
    logic vga_req;
    logic [ADDR_WIDTH-1:0] vga_addr;
    logic vga_gnt;
    logic vga_rvalid;
    logic [DATA_WIDTH-1:0] vga_rdata;
    logic mem_en;
    logic mem_we;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic [DATA_WIDTH-1:0] mem_rdata;
    modport slave (
        input  zero_occupancy_grid, upd_req, upd_addr, upd_delta, vga_req, vga_addr, mem_rdata,
        output occupancy_busy, upd_gnt, upd_done, vga_gnt, vga_rvalid, vga_rdata,
               mem_en, mem_we, mem_addr, mem_wdata
    );
    modport master (
        output zero_occupancy_grid, upd_req, upd_addr, upd_delta, vga_req, vga_addr, mem_rdata,
        input  occupancy_busy, upd_gnt, upd_done, vga_gnt, vga_rvalid, vga_rdata,
               mem_en, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/occupancy_grid_arbiter_logodds_sat_add.sv
// logodds_sat_add: signed add clamped to the representable log-odds range
module logodds_sat_add
    import occupancy_pkg::*;
#(
    parameter int W = LOGODDS_WIDTH
) (
    input  logic signed [W-1:0] a_i,
    input  logic signed [W-1:0] b_i,
    output logic signed [W-1:0] sum_o
);
    logic signed [W:0] s;
    assign s = (W + 1)'(a_i) + (W + 1)'(b_i);
    assign sum_o = (s[W] == s[W-1]) ? s[W-1:0] : {s[W], {(W - 1){~s[W]}}};
endmodule

// File: rtl/occupancy_grid_arbiter.sv
// occupancy_grid_arbiter: shares the grid BRAM port among clear sweep, RMW updates and VGA reads; OCC_ARB_FAIRNESS_EN bounds VGA grant streaks
module occupancy_grid_arbiter
    import occupancy_pkg::*;
#(
    parameter int ADDR_WIDTH = GRID_ADDR_WIDTH,
    parameter int DATA_WIDTH = LOGODDS_WIDTH,
    parameter int READ_LATENCY = 1,
    parameter int MAX_VGA_STREAK = 8
) (
    input logic clock,
    input logic reset,
    occupancy_grid_arbiter_if.slave bus
);
    if (READ_LATENCY < 1 || MAX_VGA_STREAK < 1) begin : g_bad_param
        $error("occupancy_grid_arbiter: READ_LATENCY and MAX_VGA_STREAK must be at least 1");
    end
    arb_state_t state_q, state_d;
    logic [ADDR_WIDTH:0] cnt_q, cnt_d;
    logic clear_pending_q, clear_pending_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] delta_q, delta_d;
    logic [READ_LATENCY-1:0] rv_q;
    logic [DATA_WIDTH-1:0] sat;
    logic idle, fair, vga_win, upd_win, writing, clearing;
    // grants and port drive are suppressed while reset is high so nothing leaks out mid-reset
    assign idle = state_q == IDLE && !reset && !clear_pending_q;
    assign vga_win = idle && bus.vga_req && !fair;
    assign upd_win = idle && bus.upd_req && !vga_win;
    assign writing = state_q == UPD_WR && !reset;
    assign clearing = state_q == CLEAR && !reset;
    assign bus.vga_gnt = vga_win;
    assign bus.upd_gnt = upd_win;
    assign bus.upd_done = writing;
    assign bus.occupancy_busy = clear_pending_q;
    assign bus.mem_en = vga_win || upd_win || writing || clearing;
    assign bus.mem_we = writing || clearing;
    assign bus.mem_addr = vga_win ? bus.vga_addr : upd_win ? bus.upd_addr :
                          writing ? addr_q : clearing ? cnt_q[ADDR_WIDTH-1:0] : '0;
    assign bus.mem_wdata = writing ? sat : '0;
    assign bus.vga_rvalid = rv_q[READ_LATENCY-1];
    assign bus.vga_rdata = bus.vga_rvalid ? bus.mem_rdata : '0;
    logodds_sat_add #(.W(DATA_WIDTH)) u_sat (
        .a_i  (bus.mem_rdata),
        .b_i  (delta_q),
        .sum_o(sat)
    );
`ifdef OCC_ARB_FAIRNESS_EN
    localparam int SW = $clog2(MAX_VGA_STREAK + 1);
    logic [SW-1:0] streak_q;
    assign fair = streak_q == SW'(MAX_VGA_STREAK);
    always_ff @(posedge clock)
        streak_q <= (reset || !bus.upd_req || upd_win) ? '0 : streak_q + SW'(vga_win);
`else
    assign fair = 1'b0;
`endif
    always_comb begin
        state_d = state_q;
        cnt_d = cnt_q;
        addr_d = addr_q;
        delta_d = delta_q;
        clear_pending_d = clear_pending_q || (bus.zero_occupancy_grid && state_q != CLEAR);
        case (state_q)
            IDLE: begin
                if (clear_pending_q) begin
                    state_d = CLEAR;
                    cnt_d = '0;
                end else if (upd_win) begin
                    state_d = READ_LATENCY == 1 ? UPD_WR : UPD_WAIT;
                    cnt_d = (ADDR_WIDTH + 1)'(1);
                    addr_d = bus.upd_addr;
                    delta_d = bus.upd_delta;
                end
            end
            UPD_WAIT: begin
                state_d = cnt_q == (ADDR_WIDTH + 1)'(READ_LATENCY - 1) ? UPD_WR : UPD_WAIT;
                cnt_d = cnt_q + 1'b1;
            end
            UPD_WR: state_d = IDLE;
            default: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_d[ADDR_WIDTH]) begin
                    state_d = IDLE;
                    clear_pending_d = 1'b0;
                end
            end
        endcase
    end
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q <= '0;
            clear_pending_q <= 1'b0;
            addr_q <= '0;
            delta_q <= '0;
            rv_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q <= cnt_d;
            clear_pending_q <= clear_pending_d;
            addr_q <= addr_d;
            delta_q <= delta_d;
            rv_q <= READ_LATENCY'({rv_q, vga_win});
        end
    end
endmodule

// File: tb/tb_occupancy_grid_arbiter.sv
// tb_occupancy_grid_arbiter: scoreboard bench for the grid arbiter with a behavioural BRAM
module tb_occupancy_grid_arbiter;
    localparam int AW = 4, DW = 8, RL = 2, MS = 8, DEPTH = 16;
`ifdef OCC_ARB_FAIRNESS_EN
    localparam int FV = 24, FU = 3;
`else
    localparam int FV = 33, FU = 0;
`endif
    typedef struct { logic [AW-1:0] a; logic [DW-1:0] d; } wr_t;
    typedef struct { logic [DW-1:0] d; int due; } rd_t;
    typedef struct { logic [DW-1:0] init; logic [DW-1:0] delta; logic [DW-1:0] exp; } sat_vec_t;
    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;
    occupancy_grid_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();
    occupancy_grid_arbiter #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .READ_LATENCY(RL), .MAX_VGA_STREAK(MS)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus)
    );
    logic [DW-1:0] mem [DEPTH];
    logic [DW-1:0] rpipe [RL];
    logic bd_en = 1'b0;
    logic [AW-1:0] bd_addr = '0;
    logic [DW-1:0] bd_data = '0;
    always @(posedge clock) begin
        if (bd_en) mem[bd_addr] <= bd_data;
        else if (bus.mem_en && bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;
        rpipe[0] <= mem[bus.mem_addr];
        for (int i = 1; i < RL; i++) rpipe[i] <= rpipe[i-1];
    end
    assign bus.mem_rdata = rpipe[RL-1];
    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;
    int checks = 0, errors = 0;
    int vga_gnts = 0, upd_gnts = 0, wr_cnt = 0, wr_first = 0, wr_last = 0;
    logic [DW-1:0] ref_grid [DEPTH];
    wr_t wq[$];
    rd_t rq[$];
    wr_t wm;
    rd_t rm;
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask
    function automatic logic [31:0] outs();
        return {5'd0, bus.occupancy_busy, bus.upd_gnt, bus.upd_done, bus.vga_gnt, bus.vga_rvalid,
                bus.vga_rdata, bus.mem_en, bus.mem_we, bus.mem_addr, bus.mem_wdata};
    endfunction
    always @(negedge clock) begin
        if (bus.vga_gnt) begin
            rq.push_back(rd_t'{ref_grid[bus.vga_addr], cyc + RL});
            vga_gnts++;
        end
        if (bus.upd_gnt) upd_gnts++;
        if (bus.vga_rvalid) begin
            if (rq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL vga_rvalid: got read data %0h, required no read pending", bus.vga_rdata);
            end else begin
                rm = rq.pop_front();
                chk("vga_rdata", 32'(bus.vga_rdata), 32'(rm.d));
                chk("vga_rlat", cyc, rm.due);
            end
        end
        if (bus.mem_en && bus.mem_we) begin
            if (wr_cnt == 0) wr_first = cyc;
            wr_last = cyc;
            wr_cnt++;
            if (wq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL mem_write: got write addr %0d data %0h, required no write", bus.mem_addr, bus.mem_wdata);
            end else begin
                wm = wq.pop_front();
                chk("wr_addr", 32'(bus.mem_addr), 32'(wm.a));
                chk("wr_data", 32'(bus.mem_wdata), 32'(wm.d));
            end
        end
    end
    task automatic tick();
        @(posedge clock);
        #1;
    endtask
    task automatic backdoor(input logic [AW-1:0] a, input logic [DW-1:0] d);
        tick();
        bd_en = 1'b1;
        bd_addr = a;
        bd_data = d;
        tick();
        bd_en = 1'b0;
        ref_grid[a] = d;
    endtask
    task automatic wait_upd_gnt(output bit ok, output int at);
        ok = 0;
        at = 0;
        for (int k = 0; k < 20 && !ok; k++) begin
            @(negedge clock);
            if (bus.upd_gnt) begin ok = 1; at = cyc; end
        end
    endtask
    task automatic wait_upd_done(output bit ok, output int at);
        ok = 0;
        at = 0;
        for (int k = 0; k < 20 && !ok; k++) begin
            @(negedge clock);
            if (bus.upd_done) begin ok = 1; at = cyc; end
        end
    endtask
    task automatic wait_busy_low(input int lim, output bit ok, output int at);
        ok = 0;
        at = 0;
        for (int k = 0; k < lim && !ok; k++) begin
            @(negedge clock);
            if (!bus.occupancy_busy) begin ok = 1; at = cyc; end
        end
    endtask
    task automatic push_clear();
        for (int i = 0; i < DEPTH; i++) wq.push_back(wr_t'{AW'(i), '0});
    endtask
    initial begin
        #100000;
        $display("FAIL watchdog: got no finish by time limit, required finish");
        $fatal(1, "watchdog");
    end
    initial begin
        sat_vec_t tv[8];
        bit ok;
        int g, d, bad;
        tv[0] = '{8'd120, 8'd20, 8'd127};
        tv[1] = '{8'(-120), 8'(-20), 8'(-128)};
        tv[2] = '{8'd3, 8'(-5), 8'(-2)};
        tv[3] = '{8'd127, 8'd1, 8'd127};
        tv[4] = '{8'(-128), 8'(-1), 8'(-128)};
        tv[5] = '{8'(-128), 8'd127, 8'(-1)};
        tv[6] = '{8'd50, 8'(-60), 8'(-10)};
        tv[7] = '{8'd0, 8'd0, 8'd0};
        bus.zero_occupancy_grid = 0;
        bus.upd_req = 0;
        bus.upd_addr = '0;
        bus.upd_delta = '0;
        bus.vga_req = 0;
        bus.vga_addr = '0;
        repeat (3) @(posedge clock);
        @(negedge clock);
        chk("reset_outputs", outs(), 0);
        tick();
        reset = 0;
        bus.zero_occupancy_grid = 1;
        wr_cnt = 0;
        push_clear();
        @(negedge clock);
        chk("busy_before_clear", 32'(bus.occupancy_busy), 0);
        tick();
        bus.zero_occupancy_grid = 0;
        @(negedge clock);
        chk("busy_rise", 32'(bus.occupancy_busy), 1);
        wait_busy_low(40, ok, d);
        chk("clear_finished", 32'(ok), 1);
        chk("clear_writes", wr_cnt, DEPTH);
        chk("clear_consecutive", wr_last - wr_first, DEPTH - 1);
        chk("busy_fall", d, wr_last + 1);
        for (int i = 0; i < DEPTH; i++) ref_grid[i] = '0;
        for (int i = 0; i < 8; i++) begin
            backdoor(5, tv[i].init);
            wq.push_back(wr_t'{4'd5, tv[i].exp});
            tick();
            bus.upd_req = 1;
            bus.upd_addr = 5;
            bus.upd_delta = tv[i].delta;
            wait_upd_gnt(ok, g);
            chk("sat_gnt", 32'(ok), 1);
            tick();
            bus.upd_req = 0;
            wait_upd_done(ok, d);
            chk("sat_done", 32'(ok), 1);
            chk("sat_done_lat", d - g, RL);
            ref_grid[5] = tv[i].exp;
            tick();
            chk("sat_cell", 32'(mem[5]), 32'(tv[i].exp));
        end
        vga_gnts = 0;
        upd_gnts = 0;
        wq.push_back(wr_t'{4'd3, 8'd7});
        bus.vga_req = 1;
        bus.upd_req = 1;
        bus.upd_addr = 3;
        bus.upd_delta = 7;
        for (int k = 0; k < 4; k++) begin
            bus.vga_addr = AW'(k);
            tick();
        end
        bus.vga_req = 0;
        chk("contend_vga_gnts", vga_gnts, 4);
        chk("contend_upd_gnts", upd_gnts, 0);
        @(negedge clock);
        chk("upd_after_vga_drop", 32'(bus.upd_gnt), 1);
        tick();
        bus.upd_req = 0;
        wait_upd_done(ok, d);
        chk("contend_done", 32'(ok), 1);
        ref_grid[3] = 8'd7;
        repeat (4) tick();
        chk("contend_reads_drained", rq.size(), 0);
        backdoor(9, 8'd10);
        wq.push_back(wr_t'{4'd9, 8'd15});
        push_clear();
        tick();
        bus.upd_req = 1;
        bus.upd_addr = 9;
        bus.upd_delta = 5;
        wait_upd_gnt(ok, g);
        chk("rmw_clear_gnt", 32'(ok), 1);
        tick();
        bus.upd_req = 0;
        tick();
        bus.zero_occupancy_grid = 1;
        @(negedge clock);
        chk("rmw_write_with_clear", 32'(bus.upd_done), 1);
        tick();
        bus.zero_occupancy_grid = 0;
        wait_busy_low(50, ok, d);
        chk("rmw_clear_finished", 32'(ok), 1);
        bad = 0;
        for (int i = 0; i < DEPTH; i++) if (mem[i] !== '0) bad++;
        chk("grid_zero_after_rmw_clear", bad, 0);
        chk("rmw_clear_writes_drained", wq.size(), 0);
        for (int i = 0; i < DEPTH; i++) ref_grid[i] = '0;
        tick();
        vga_gnts = 0;
        upd_gnts = 0;
        for (int k = 1; k <= FU; k++) wq.push_back(wr_t'{4'd4, 8'(k)});
        bus.vga_req = 1;
        bus.vga_addr = 6;
        bus.upd_req = 1;
        bus.upd_addr = 4;
        bus.upd_delta = 1;
        repeat (33) tick();
        bus.vga_req = 0;
        chk("fair_vga_gnts", vga_gnts, FV);
        chk("fair_upd_gnts", upd_gnts, FU);
        wq.push_back(wr_t'{4'd4, 8'(FU + 1)});
        wait_upd_gnt(ok, g);
        chk("fair_final_gnt", 32'(ok), 1);
        tick();
        bus.upd_req = 0;
        wait_upd_done(ok, d);
        chk("fair_final_done", 32'(ok), 1);
        ref_grid[4] = 8'(FU + 1);
        backdoor(12, 8'd33);
        tick();
        bus.zero_occupancy_grid = 1;
        wr_cnt = 0;
        push_clear();
        tick();
        bus.zero_occupancy_grid = 0;
        ok = 0;
        for (int k = 0; k < 30 && !ok; k++) begin
            @(negedge clock);
            ok = bus.mem_we && bus.mem_addr == 7;
        end
        chk("sweep_reached_7", 32'(ok), 1);
        tick();
        reset = 1;
        wq.delete();
        tick();
        @(negedge clock);
        chk("reset_mid_clear_outputs", outs(), 0);
        tick();
        reset = 0;
        @(negedge clock);
        chk("after_reset_outputs", outs(), 0);
        tick();
        bus.vga_req = 1;
        bus.vga_addr = 12;
        @(negedge clock);
        chk("vga_after_reset", 32'(bus.vga_gnt), 1);
        tick();
        bus.vga_req = 0;
        repeat (4) tick();
        chk("cell_kept_after_abort", 32'(mem[12]), 33);
        chk("partial_clear_count", wr_cnt, 8);
        chk("writes_drained", wq.size(), 0);
        chk("reads_drained", rq.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
